// File: rtl/sub_pkg.sv
// Shared types and elaboration-time helpers for the serial subtractor.
package sub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Number of slice cycles; returns 0 when n is not a multiple of k so the top can reject it.
   function automatic int unsigned cycles_f(input int unsigned n, input int unsigned k);
      if (k == 0 || (n % k) != 0) return 0;
      return n / k;
   endfunction

   function automatic int unsigned cnt_width_f(input int unsigned n, input int unsigned k);
      int unsigned c;
      c = cycles_f(n, k);
      if (c <= 1) return 1;
      return $clog2(c);
   endfunction

endpackage

// File: rtl/sub_slice_k.sv
// Combinational K-bit ripple of full-subtractor cells: diff = x - y - bi.
module sub_slice_k #(
   parameter int unsigned K = 1
) (
   input  logic [K-1:0] x,
   input  logic [K-1:0] y,
   input  logic         bi,
   output logic [K-1:0] diff,
   output logic         bo
);

   logic w_b;

   always_comb begin
      diff = '0;
      w_b  = bi;
      for (int unsigned i = 0; i < K; i++) begin
         diff[i] = x[i] ^ y[i] ^ w_b;
         w_b     = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_b);
      end
      bo = w_b;
   end

endmodule

// File: rtl/serial_subtractor_n.sv
// Multi-cycle N-bit subtractor d = a - b - bin, K bits per clock LSB-first,
// with start/busy/done handshake and borrow/zero/negative/overflow flags.
module serial_subtractor_n
   import sub_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned K = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] d,
   output logic         bout,
   output logic         zero,
   output logic         neg,
   output logic         ovf
);

   localparam int unsigned CYCLES = cycles_f(N, K);
   localparam int unsigned CW     = cnt_width_f(N, K);

   if (CYCLES == 0 || N < 2) begin : g_bad_params
      $error("serial_subtractor_n: N must be >= 2 and a multiple of K");
   end

   state_t          r_state, w_state_nx;
   logic [N-1:0]    r_a, r_b, r_res;
   logic            r_borrow, r_a_msb, r_b_msb;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_d;
   logic            r_bout, r_zero, r_neg, r_ovf;

   logic [K-1:0]    w_diff;
   logic            w_bo;
   logic [N+K-1:0]  w_cat;
   logic [N-1:0]    w_res_nx;
   logic            w_last;

   sub_slice_k #(.K(K)) u_slice (
      .x    (r_a[K-1:0]),
      .y    (r_b[K-1:0]),
      .bi   (r_borrow),
      .diff (w_diff),
      .bo   (w_bo)
   );

   // New slice enters from the MSB side; written as a wide shift so K == N needs no special case.
   assign w_cat    = {w_diff, r_res} >> K;
   assign w_res_nx = w_cat[N-1:0];
   assign w_last   = (r_cnt == CW'(CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         IDLE: if (start) w_state_nx = RUN;
         RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nx = DONE;
         end
         DONE: begin
            done       = 1'b1;
            w_state_nx = IDLE;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_cnt    <= '0;
         r_d      <= '0;
         r_bout   <= 1'b0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_a      <= a;
               r_b      <= b;
               r_borrow <= bin;
               r_a_msb  <= a[N-1];
               r_b_msb  <= b[N-1];
               r_cnt    <= '0;
            end
            RUN: begin
               r_a      <= r_a >> K;
               r_b      <= r_b >> K;
               r_res    <= w_res_nx;
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_d    <= w_res_nx;
                  r_bout <= w_bo;
                  r_zero <= (w_res_nx == '0);
                  r_neg  <= w_res_nx[N-1];
                  r_ovf  <= (r_a_msb != r_b_msb) && (w_res_nx[N-1] != r_a_msb);
               end
            end
            default: ;
         endcase
      end
   end

   assign d    = r_d;
   assign bout = r_bout;
   assign zero = r_zero;
   assign neg  = r_neg;
   assign ovf  = r_ovf;

endmodule

// File: doc/serial_subtractor_n.md
Name: serial_subtractor_n

Overview:
Parametrised multi-cycle N-bit subtractor for the ALU datapath. It computes d = a - b - bin, processing K bits per clock LSB-first and carrying the borrow between cycles in a register. It uses a start/busy/done handshake and produces borrow, zero, negative and signed-overflow flags. It replaces the single-bit combinational full subtractor wherever area matters more than latency.

Parameters:
N, 4, operand/result width in bits; N >= 2.
K, 1, bits processed per clock; N must be a multiple of K (elaboration-time error otherwise).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  N  minuend, captured on the accepted start edge
b  input  N  subtrahend, captured on the accepted start edge
bin  input  1  borrow-in, captured on the accepted start edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when results update
d  output  N  difference, registered, held until the next completion
bout  output  1  unsigned borrow-out (a < b + bin)
zero  output  1  d == 0
neg  output  1  d[N-1]
ovf  output  1  signed overflow: a[N-1] != b[N-1] and d[N-1] != a[N-1]

Behaviour:
- Derived constant: CYCLES = N/K.
- States: IDLE, RUN, DONE.
- Reset: state is IDLE. busy, done, d, bout, zero, neg and ovf are all 0. The internal borrow register, slice counter and shift registers are 0.
- IDLE:
  - start=1 at a rising edge: capture a, b and bin; set count=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Process the K LSBs of the shifted operand registers with the current borrow.
  - Shift the result slice into the result register from the MSB side.
  - Update the borrow; increment count.
  - When count reaches CYCLES-1 on this edge, go to DONE and load d and all flags from the completed result.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: done is high in the cycle that begins CYCLES edges after the start-sampling edge. Example: N=4, K=1 gives 4 edges.
- busy = (state == RUN). busy and done are never high together.
- start while in RUN or DONE is ignored. Operands are not re-captured and there is no queuing.
- a, b and bin may change freely after the accepted start edge without affecting the result.
- Width rules:
  - d is the N-bit two's-complement wrap of a - b - bin.
  - bout is the final slice borrow.
  - Flags derive only from the captured operands and d.
- Reset mid-operation (rst=1 in RUN or DONE): abandon the operation; IDLE next cycle; no done pulse; outputs cleared to 0.
- rst has priority over start on the same edge.
- Output stability: d and the flags change only on the DONE-entry edge or on reset.

Decomposition:
- Package sub_pkg holds:
  - enum state_t {IDLE, RUN, DONE};
  - a function computing CYCLES with the divisibility check;
  - the count width, $clog2(N/K) with a minimum of 1.
- One sub-module, sub_slice_k: a combinational K-bit ripple of full-subtractor cells.
  - Inputs: x[K], y[K], bi.
  - Outputs: diff[K], bo.
  - Instantiated once in the top level.

Test Plan:
- N=4, K=1; a=5, b=3, bin=0, start pulse -> busy for 4 cycles, then done=1 with d=2, bout=0, zero=0, neg=0, ovf=0.
- N=4, K=1; a=3, b=5, bin=0 -> d=4'hE, bout=1, neg=1, ovf=0, zero=0.
- N=4, K=1; a=8, b=1, bin=0 -> d=7, ovf=1, bout=0, neg=0. Then a=4, b=3, bin=1 -> d=0, zero=1, bout=0.
- Run a=5, b=3; assert start with a=0, b=1 in RUN cycle 2 -> ignored; d=2 at done; inputs changed after capture have no effect.
- Assert rst in RUN cycle 2 -> no done pulse, all outputs 0 and IDLE next cycle. Then a fresh start with a=9, b=4 -> d=5 after 4 cycles.
- N=8, K=2; a=8'h00, b=8'h01, bin=1 -> done after 4 cycles, d=8'hFE, bout=1, neg=1, ovf=0.
